// File: rtl/bridge_timer.sv
// bridge_timer: memory-mapped countdown timer with one-shot/auto-reload modes and a level irq towards CP0
module bridge_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d, count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        hit, wr_ctrl, wr_preset;
  logic [1:0]  off;
  logic        unused_addr_lsb;
  always_comb begin
    hit = addr[31:4] == BASE[31:4];
    off = addr[3:2];
    unused_addr_lsb = ^addr[1:0];
    wr_ctrl = we && hit && off == 2'd0;
    wr_preset = we && hit && off == 2'd1;
    rdata = !hit ? '0 :
            off == 2'd0 ? {28'd0, ctrl_q} :
            off == 2'd1 ? preset_q :
            off == 2'd2 ? count_q : '0;
    irq = irq_flag_q & ctrl_q[3];
  end
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    preset_d = preset_q;
    count_d = count_q;
    irq_flag_d = irq_flag_q;
    case (state_q)
      IDLE: state_d = ctrl_q[0] ? LOAD : IDLE;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          irq_flag_d = 1'b1;
          state_d = INT;
        end
      end
      default: begin
        if (ctrl_q[2:1] == 2'b01) begin
          irq_flag_d = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
    // CPU writes override the FSM's own EN clear and flag update on the same edge
    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = wdata;
      irq_flag_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      preset_q <= '0;
      count_q <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      preset_q <= preset_d;
      count_q <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end
endmodule

// File: doc/bridge_timer.md
Name: bridge_timer

Overview:
- Memory-mapped countdown timer; a bus responder on the CPU's bridge.
- The CPU's load/store path initiates word reads and writes. This block decodes them and returns read data.
- It counts down from a programmed preset and raises an interrupt request towards CP0.
- Two timer instances share one bridge, distinguished by BASE.

Parameters:
- BASE, 32'h0000_7F00, byte address of register 0; the 16-byte window BASE..BASE+0xF is decoded.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- addr  input  32  byte address from bridge; bits [1:0] ignored
- we  input  1  write strobe, sampled on rising edge
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr
- irq  output  1  interrupt request to CP0, level

Behaviour:
- Decode: hit = (addr[31:4] == BASE[31:4]). Offsets 0x0 = CTRL, 0x4 = PRESET, 0x8 = COUNT, 0xC = reserved.
- CTRL fields:
  - [0] EN
  - [2:1] MODE
  - [3] IM
  - [31:4] read as 0, writes ignored
- PRESET: 32-bit read/write.
- COUNT: read-only; writes to COUNT and to 0xC are ignored.
- rdata:
  - combinational from current registers
  - 0 when not hit or offset is 0xC
  - a read in the same cycle as a write returns the pre-write value
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so irq=0 and rdata=0 for non-hit.
- irq = irq_flag & CTRL.IM.
- Any CPU write to CTRL or PRESET clears irq_flag on that edge.
- FSM, one transition per clock:
  - IDLE: if EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT: if EN=0 -> IDLE, COUNT holds. Else if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0, irq_flag<=1, -> INT.
  - INT, MODE=00/10/11 (one-shot): EN<=0; -> IDLE; irq_flag held until a CTRL/PRESET write.
  - INT, MODE=01 (auto-reload): -> LOAD; irq_flag<=0 on that edge, giving a one-cycle irq pulse.
- Latency: EN written at edge t, PRESET=N, N>=1.
  - LOAD at t+1.
  - COUNT=N at t+2, then decrements by 1 per cycle.
  - COUNT=1 at t+N+1.
  - INT with irq_flag=1 at t+N+2.
  - PRESET=0 behaves as PRESET=1 (INT at t+3).
- Simultaneous events:
  - CPU write to CTRL on the same edge as the one-shot EN clear: the CPU write wins and irq_flag is cleared.
  - PRESET written while in CNT: no effect on the running COUNT; takes effect at the next LOAD.
  - EN cleared while in LOAD: LOAD still completes, then CNT sees EN=0 -> IDLE.
- Reset mid-count: reset wins over every write and FSM action on that edge; all state returns to reset values.
- Arithmetic: unsigned 32-bit. COUNT never decrements below 0 and never wraps.

Test Plan:
- Reset then idle: pulse reset 2 cycles, read 0x7F00/04/08 -> all 0, irq=0. Read 0x7F0C and 0x1234 -> 0.
- One-shot: write PRESET=5, then CTRL=0x9 (EN, MODE=00, IM).
  - -> COUNT reads 5,4,3,2,1 on consecutive cycles, then 0.
  - -> irq rises 7 cycles after the CTRL write edge and stays high.
  - -> CTRL reads 0x8.
  - Write CTRL=0x8 -> irq falls on that edge.
- Auto-reload: PRESET=3, CTRL=0xB.
  - -> irq is a one-cycle pulse every 5 cycles.
  - -> COUNT sequence 3,2,1,0,(LOAD),3,... repeating; CTRL stays 0xB.
- Mask/stop: PRESET=10, CTRL=0x1 (IM=0).
  - -> count completes with irq=0; internal flag is set, so writing CTRL=0x8 sets IM but clears the flag and irq stays 0.
  - Separately, CTRL=0x0 mid-count at COUNT=6 -> COUNT frozen at 6, IDLE.
- Write collisions: write COUNT=0xFF mid-count -> ignored. Write PRESET=2 mid-count -> current run unaffected; the next reload uses 2.
- Reset mid-operation: assert reset while COUNT=4 in auto-reload -> next edge all registers 0, irq=0, no further counting.
